// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard slice.
//   REG_ADDR_W  - architectural register address width
//   NUM_REGS    - number of architectural registers (x0 included)
//   FLUSH_CNT_W - width of the flush down-counter (flush length 1..15)
//   state_e     - sequencing FSM state encoding
//   reg_onehot  - one-hot decode of a register address; x0 decodes to zero
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int NUM_REGS    = 32;
  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // x0 never participates in any check, so it decodes to an empty mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    reg_onehot = '0;
    if (addr != '0) reg_onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard scoreboard signal bundle.
//   master : pipeline side, drives decode/forwarding/writeback/branch info,
//            receives operand selects and control outputs
//   slave  : scoreboard side
// Parameters: NUM_FWD forwarding stages (index 0 youngest), CNT_W width of
// the stall-cycle counter.
interface hazard_scoreboard_if #(
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 32
);
  import hazard_scoreboard_pkg::*;

  localparam int SEL_W = $clog2(NUM_FWD + 1);

  logic                          id_valid;
  logic [REG_ADDR_W-1:0]         id_rs1;
  logic [REG_ADDR_W-1:0]         id_rs2;
  logic                          id_rs1_used;
  logic                          id_rs2_used;
  logic [REG_ADDR_W-1:0]         id_rd;
  logic                          id_reg_wr;
  logic                          id_long_lat;
  logic [NUM_FWD-1:0]            fwd_valid;
  logic [NUM_FWD-1:0]            fwd_reg_wr;
  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd;
  logic [NUM_FWD-1:0]            fwd_ready;
  logic                          ll_wb_valid;
  logic [REG_ADDR_W-1:0]         ll_wb_rd;
  logic                          br_taken;

  logic [SEL_W-1:0]              fwd_sel_a;
  logic [SEL_W-1:0]              fwd_sel_b;
  logic                          stall;
  logic                          flush;
  logic                          issue;
  logic                          sb_busy;
  logic [CNT_W-1:0]              stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_wr, id_long_lat, fwd_valid, fwd_reg_wr, fwd_rd, fwd_ready,
           ll_wb_valid, ll_wb_rd, br_taken,
    input  fwd_sel_a, fwd_sel_b, stall, flush, issue, sb_busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_wr, id_long_lat, fwd_valid, fwd_reg_wr, fwd_rd, fwd_ready,
           ll_wb_valid, ll_wb_rd, br_taken,
    output fwd_sel_a, fwd_sel_b, stall, flush, issue, sb_busy, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_fwd_select.sv
// Per-operand bypass selection.
//   rs, rs_used       - source register and whether it is actually read
//   fwd_valid/reg_wr/
//   fwd_rd/fwd_ready  - forwarding stage vectors, index 0 youngest
//   sel               - 0 = register file, k = stage k-1
//   data_stall        - youngest matching stage has no result yet
module fwd_select
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [REG_ADDR_W-1:0]         rs,
  input  logic                          rs_used,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0]            fwd_reg_wr,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]            fwd_ready,
  output logic [SEL_W-1:0]              sel,
  output logic                          data_stall
);

  // Walk oldest to youngest so the youngest match is the last writer.
  // A non-ready youngest match must stall rather than fall back to an
  // older stage holding a stale value.
  always_comb begin
    sel        = '0;
    data_stall = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_reg_wr[i] && rs_used && (rs != '0) &&
          (fwd_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
        sel        = fwd_ready[i] ? SEL_W'(i + 1) : '0;
        data_stall = ~fwd_ready[i];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard detection: bypass selection, long-latency scoreboard,
// WAW protection and branch flush sequencing.
//   clk, rst - clock, synchronous active-high reset
//   hs       - pipeline bundle (slave side): decode operands, forwarding
//              stages, long-latency writeback, branch redirect in;
//              fwd_sel_a/b, stall, flush, issue, sb_busy, stall_cycles out
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_RUN   | no hazard, decode advancing normally
// ST_STALL | decode held by a data, scoreboard or WAW hazard
// ST_FLUSH | squashing fetch/decode after a redirect, counter running
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_FWD      = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input logic                 clk,
  input logic                 rst,
  hazard_scoreboard_if.slave  hs
);

  localparam int SEL_W = $clog2(NUM_FWD + 1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [NUM_REGS-1:0]     pending_q, pending_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;

  logic [SEL_W-1:0]        sel_a, sel_b;
  logic                    dstall_a, dstall_b;
  logic [NUM_REGS-1:0]     wb_mask, set_mask, eff_pending;
  logic                    sb_a, sb_b, waw, hazard;
  logic                    stall, flush, issue;

  fwd_select #(.NUM_FWD(NUM_FWD)) u_fwd_a (
    .rs         (hs.id_rs1),
    .rs_used    (hs.id_rs1_used),
    .fwd_valid  (hs.fwd_valid),
    .fwd_reg_wr (hs.fwd_reg_wr),
    .fwd_rd     (hs.fwd_rd),
    .fwd_ready  (hs.fwd_ready),
    .sel        (sel_a),
    .data_stall (dstall_a)
  );

  fwd_select #(.NUM_FWD(NUM_FWD)) u_fwd_b (
    .rs         (hs.id_rs2),
    .rs_used    (hs.id_rs2_used),
    .fwd_valid  (hs.fwd_valid),
    .fwd_reg_wr (hs.fwd_reg_wr),
    .fwd_rd     (hs.fwd_rd),
    .fwd_ready  (hs.fwd_ready),
    .sel        (sel_b),
    .data_stall (dstall_b)
  );

  // A writeback landing this cycle already makes its register readable.
  assign wb_mask     = hs.ll_wb_valid ? reg_onehot(hs.ll_wb_rd) : '0;
  assign eff_pending = pending_q & ~wb_mask;

  assign sb_a   = hs.id_rs1_used && eff_pending[hs.id_rs1] && (sel_a == '0);
  assign sb_b   = hs.id_rs2_used && eff_pending[hs.id_rs2] && (sel_b == '0);
  assign waw    = hs.id_reg_wr && eff_pending[hs.id_rd];
  assign hazard = dstall_a | dstall_b | sb_a | sb_b | waw;

  assign stall = hazard && hs.id_valid && !hs.br_taken && (state_q != ST_FLUSH);
  assign flush = hs.br_taken || (state_q == ST_FLUSH);
  assign issue = hs.id_valid && !stall && !flush;

  assign set_mask = (issue && hs.id_reg_wr && hs.id_long_lat) ? reg_onehot(hs.id_rd) : '0;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (hs.br_taken) begin
      // A single-cycle flush never leaves RUN; the redirect cycle itself flushes.
      flush_cnt_d = FLUSH_LOAD;
      state_d     = (FLUSH_LOAD == '0) ? ST_RUN : ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   if (stall)  state_d = ST_STALL;
        ST_STALL: if (!stall) state_d = ST_RUN;
        ST_FLUSH: begin
          flush_cnt_d = (flush_cnt_q == '0) ? '0 : flush_cnt_q - FLUSH_CNT_W'(1);
          if (flush_cnt_d == '0) state_d = ST_RUN;
        end
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Flush leaves pending bits alone: in-flight long ops still write back.
  always_comb begin
    pending_d    = (pending_q & ~wb_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      pending_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hs.fwd_sel_a    = sel_a;
  assign hs.fwd_sel_b    = sel_b;
  assign hs.stall        = stall;
  assign hs.flush        = flush;
  assign hs.issue        = issue;
  assign hs.sb_busy      = |pending_q;
  assign hs.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int NF = 2;
  localparam int FC = 3;
  localparam int CW = 4;
  localparam int SW = $clog2(NF + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_FWD(NF), .CNT_W(CW)) hs();

  hazard_scoreboard #(.NUM_FWD(NF), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hs  (hs)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: set of outstanding long-latency destinations, cycles of
  // flush still owed after the current one, and the saturating stall count.
  bit m_pend [32];
  int m_flush_rem;
  int m_stall_cnt;

  int e_sel_a, e_sel_b;
  bit e_stall, e_flush, e_issue, e_busy;

  function automatic int m_sel(input logic [4:0] rs, input logic used, output bit dstall);
    dstall = 1'b0;
    if (!used || rs == 5'd0) return 0;
    for (int i = 0; i < NF; i++) begin
      if (hs.fwd_valid[i] && hs.fwd_reg_wr[i] && hs.fwd_rd[i*5 +: 5] == rs) begin
        if (hs.fwd_ready[i]) return i + 1;
        dstall = 1'b1;
        return 0;
      end
    end
    return 0;
  endfunction

  function automatic bit m_avail_pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (hs.ll_wb_valid && hs.ll_wb_rd == r) return 1'b0;
    return m_pend[r];
  endfunction

  task automatic model_eval();
    bit da, db, hz;
    e_sel_a = m_sel(hs.id_rs1, hs.id_rs1_used, da);
    e_sel_b = m_sel(hs.id_rs2, hs.id_rs2_used, db);
    hz = da || db
         || (hs.id_rs1_used && m_avail_pending(hs.id_rs1) && e_sel_a == 0)
         || (hs.id_rs2_used && m_avail_pending(hs.id_rs2) && e_sel_b == 0)
         || (hs.id_reg_wr && m_avail_pending(hs.id_rd));
    e_flush = hs.br_taken || (m_flush_rem > 0);
    e_stall = hz && hs.id_valid && !hs.br_taken && (m_flush_rem == 0);
    e_issue = hs.id_valid && !e_stall && !e_flush;
    e_busy  = 1'b0;
    for (int r = 0; r < 32; r++) if (m_pend[r]) e_busy = 1'b1;
  endtask

  task automatic tick();
    model_eval();
    if (rst) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
      m_flush_rem = 0;
      m_stall_cnt = 0;
    end else begin
      if (hs.ll_wb_valid) m_pend[hs.ll_wb_rd] = 1'b0;
      if (e_issue && hs.id_reg_wr && hs.id_long_lat && hs.id_rd != 5'd0) m_pend[hs.id_rd] = 1'b1;
      if (hs.br_taken) m_flush_rem = FC - 1;
      else if (m_flush_rem > 0) m_flush_rem--;
      if (e_stall && m_stall_cnt < (1 << CW) - 1) m_stall_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hs.id_valid = 0; hs.id_rs1 = 0; hs.id_rs2 = 0; hs.id_rs1_used = 0; hs.id_rs2_used = 0;
    hs.id_rd = 0; hs.id_reg_wr = 0; hs.id_long_lat = 0;
    hs.fwd_valid = '0; hs.fwd_reg_wr = '0; hs.fwd_rd = '0; hs.fwd_ready = '0;
    hs.ll_wb_valid = 0; hs.ll_wb_rd = 0; hs.br_taken = 0;
  endtask

  task automatic set_stage(input int i, input logic v, input logic [4:0] rd, input logic rdy);
    hs.fwd_valid[i] = v; hs.fwd_reg_wr[i] = v; hs.fwd_rd[i*5 +: 5] = rd; hs.fwd_ready[i] = rdy;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick();
    rst = 1'b0; #1;
    n_checks++; if (hs.flush !== 1'b0) begin n_errors++; $display("FAIL reset flush: got %b want 0", hs.flush); end
    n_checks++; if (hs.sb_busy !== 1'b0) begin n_errors++; $display("FAIL reset sb_busy: got %b want 0", hs.sb_busy); end
    n_checks++; if (hs.stall_cycles !== CW'(0)) begin n_errors++; $display("FAIL reset stall_cycles: got %0d want 0", hs.stall_cycles); end
    n_checks++; if (hs.stall !== 1'b0) begin n_errors++; $display("FAIL reset stall: got %b want 0", hs.stall); end
    n_checks++; if (hs.fwd_sel_a !== SW'(0)) begin n_errors++; $display("FAIL reset fwd_sel_a: got %0d want 0", hs.fwd_sel_a); end
  endtask

  task automatic test_ex_fwd();
    idle(); set_stage(0, 1, 5'd5, 1);
    hs.id_valid = 1; hs.id_rs1 = 5'd5; hs.id_rs1_used = 1; #1;
    n_checks++; if (hs.fwd_sel_a !== SW'(1)) begin n_errors++; $display("FAIL ex_fwd fwd_sel_a: got %0d want 1", hs.fwd_sel_a); end
    n_checks++; if (hs.stall !== 1'b0) begin n_errors++; $display("FAIL ex_fwd stall: got %b want 0", hs.stall); end
    n_checks++; if (hs.issue !== 1'b1) begin n_errors++; $display("FAIL ex_fwd issue: got %b want 1", hs.issue); end
    tick();
  endtask

  task automatic test_load_use();
    idle(); set_stage(0, 1, 5'd7, 0); set_stage(1, 1, 5'd7, 1);
    hs.id_valid = 1; hs.id_rs2 = 5'd7; hs.id_rs2_used = 1; #1;
    n_checks++; if (hs.stall !== 1'b1) begin n_errors++; $display("FAIL load_use stall: got %b want 1", hs.stall); end
    n_checks++; if (hs.fwd_sel_b !== SW'(0)) begin n_errors++; $display("FAIL load_use older_sel: got %0d want 0", hs.fwd_sel_b); end
    tick();
    hs.fwd_ready[0] = 1; #1;
    n_checks++; if (hs.fwd_sel_b !== SW'(1)) begin n_errors++; $display("FAIL load_use ready_sel: got %0d want 1", hs.fwd_sel_b); end
    n_checks++; if (hs.stall !== 1'b0) begin n_errors++; $display("FAIL load_use ready_stall: got %b want 0", hs.stall); end
    n_checks++; if (hs.stall_cycles !== CW'(1)) begin n_errors++; $display("FAIL load_use stall_cycles: got %0d want 1", hs.stall_cycles); end
    tick();
  endtask

  task automatic test_scoreboard();
    idle(); hs.id_valid = 1; hs.id_reg_wr = 1; hs.id_long_lat = 1; hs.id_rd = 5'd9; #1;
    n_checks++; if (hs.issue !== 1'b1) begin n_errors++; $display("FAIL sb issue_ll: got %b want 1", hs.issue); end
    tick();
    idle(); hs.id_valid = 1; hs.id_rs1 = 5'd9; hs.id_rs1_used = 1; #1;
    n_checks++; if (hs.sb_busy !== 1'b1) begin n_errors++; $display("FAIL sb busy_set: got %b want 1", hs.sb_busy); end
    n_checks++; if (hs.stall !== 1'b1) begin n_errors++; $display("FAIL sb raw_stall: got %b want 1", hs.stall); end
    tick();
    hs.id_rs1_used = 0; hs.id_reg_wr = 1; hs.id_rd = 5'd9; #1;
    n_checks++; if (hs.stall !== 1'b1) begin n_errors++; $display("FAIL sb waw_stall: got %b want 1", hs.stall); end
    tick();
    hs.id_reg_wr = 0; hs.id_rs1_used = 1; hs.ll_wb_valid = 1; hs.ll_wb_rd = 5'd9; #1;
    n_checks++; if (hs.stall !== 1'b0) begin n_errors++; $display("FAIL sb wb_bypass_stall: got %b want 0", hs.stall); end
    n_checks++; if (hs.issue !== 1'b1) begin n_errors++; $display("FAIL sb wb_bypass_issue: got %b want 1", hs.issue); end
    tick();
    idle(); #1;
    n_checks++; if (hs.sb_busy !== 1'b0) begin n_errors++; $display("FAIL sb busy_clear: got %b want 0", hs.sb_busy); end
    // Same-cycle set and clear of one register: the set must survive.
    hs.id_valid = 1; hs.id_reg_wr = 1; hs.id_long_lat = 1; hs.id_rd = 5'd9;
    hs.ll_wb_valid = 1; hs.ll_wb_rd = 5'd9;
    tick();
    idle(); #1;
    n_checks++; if (hs.sb_busy !== 1'b1) begin n_errors++; $display("FAIL sb set_wins: got %b want 1", hs.sb_busy); end
    hs.ll_wb_valid = 1; hs.ll_wb_rd = 5'd9;
    tick();
    idle(); #1;
    n_checks++; if (hs.sb_busy !== 1'b0) begin n_errors++; $display("FAIL sb final_clear: got %b want 0", hs.sb_busy); end
    n_checks++; if (hs.stall_cycles !== CW'(m_stall_cnt)) begin n_errors++; $display("FAIL sb stall_cycles: got %0d want %0d", hs.stall_cycles, m_stall_cnt); end
  endtask

  task automatic test_x0();
    idle(); set_stage(0, 1, 5'd0, 1); set_stage(1, 1, 5'd0, 1);
    hs.id_valid = 1; hs.id_rs1_used = 1; hs.id_rs2_used = 1;
    hs.id_reg_wr = 1; hs.id_long_lat = 1; hs.id_rd = 5'd0; #1;
    n_checks++; if (hs.fwd_sel_a !== SW'(0)) begin n_errors++; $display("FAIL x0 fwd_sel_a: got %0d want 0", hs.fwd_sel_a); end
    n_checks++; if (hs.fwd_sel_b !== SW'(0)) begin n_errors++; $display("FAIL x0 fwd_sel_b: got %0d want 0", hs.fwd_sel_b); end
    n_checks++; if (hs.stall !== 1'b0) begin n_errors++; $display("FAIL x0 stall: got %b want 0", hs.stall); end
    tick();
    idle(); #1;
    n_checks++; if (hs.sb_busy !== 1'b0) begin n_errors++; $display("FAIL x0 sb_busy: got %b want 0", hs.sb_busy); end
  endtask

  task automatic test_flush();
    bit exp_flush, exp_stall;
    idle(); set_stage(0, 1, 5'd3, 0);
    hs.id_valid = 1; hs.id_rs1 = 5'd3; hs.id_rs1_used = 1; #1;
    n_checks++; if (hs.stall !== 1'b1) begin n_errors++; $display("FAIL flush pre_stall: got %b want 1", hs.stall); end
    for (int c = 0; c < 6; c++) begin
      hs.br_taken = (c == 0 || c == 2); #1;
      exp_flush = (c <= 4);
      exp_stall = (c == 5);
      n_checks++; if (hs.flush !== exp_flush) begin n_errors++; $display("FAIL flush c%0d flush: got %b want %b", c, hs.flush, exp_flush); end
      n_checks++; if (hs.stall !== exp_stall) begin n_errors++; $display("FAIL flush c%0d stall: got %b want %b", c, hs.stall, exp_stall); end
      n_checks++; if (hs.issue !== 1'b0) begin n_errors++; $display("FAIL flush c%0d issue: got %b want 0", c, hs.issue); end
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      hs.id_valid    = ($urandom_range(0, 4) != 0);
      hs.id_rs1      = 5'($urandom_range(0, 7));
      hs.id_rs2      = 5'($urandom_range(0, 7));
      hs.id_rs1_used = 1'($urandom);
      hs.id_rs2_used = 1'($urandom);
      hs.id_rd       = 5'($urandom_range(0, 7));
      hs.id_reg_wr   = 1'($urandom);
      hs.id_long_lat = 1'($urandom);
      for (int i = 0; i < NF; i++)
        set_stage(i, 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
      hs.fwd_reg_wr  = NF'($urandom) | ~hs.fwd_valid;
      hs.ll_wb_valid = ($urandom_range(0, 2) == 0);
      hs.ll_wb_rd    = 5'($urandom_range(0, 7));
      hs.br_taken    = ($urandom_range(0, 19) == 0);
      #1;
      model_eval();
      n_checks++; if (hs.fwd_sel_a !== SW'(e_sel_a)) begin n_errors++; $display("FAIL rand%0d fwd_sel_a: got %0d want %0d", n, hs.fwd_sel_a, e_sel_a); end
      n_checks++; if (hs.fwd_sel_b !== SW'(e_sel_b)) begin n_errors++; $display("FAIL rand%0d fwd_sel_b: got %0d want %0d", n, hs.fwd_sel_b, e_sel_b); end
      n_checks++; if (hs.stall !== e_stall) begin n_errors++; $display("FAIL rand%0d stall: got %b want %b", n, hs.stall, e_stall); end
      n_checks++; if (hs.flush !== e_flush) begin n_errors++; $display("FAIL rand%0d flush: got %b want %b", n, hs.flush, e_flush); end
      n_checks++; if (hs.issue !== e_issue) begin n_errors++; $display("FAIL rand%0d issue: got %b want %b", n, hs.issue, e_issue); end
      n_checks++; if (hs.sb_busy !== e_busy) begin n_errors++; $display("FAIL rand%0d sb_busy: got %b want %b", n, hs.sb_busy, e_busy); end
      n_checks++; if (hs.stall_cycles !== CW'(m_stall_cnt)) begin n_errors++; $display("FAIL rand%0d stall_cycles: got %0d want %0d", n, hs.stall_cycles, m_stall_cnt); end
      tick();
    end
    idle();
    for (int r = 1; r < 8; r++) begin
      hs.ll_wb_valid = 1; hs.ll_wb_rd = 5'(r); tick();
    end
    idle();
  endtask

  task automatic test_saturate();
    idle(); set_stage(0, 1, 5'd6, 0);
    hs.id_valid = 1; hs.id_rs2 = 5'd6; hs.id_rs2_used = 1;
    for (int c = 0; c < 20; c++) tick();
    #1;
    n_checks++; if (hs.stall_cycles !== CW'((1 << CW) - 1)) begin n_errors++; $display("FAIL saturate stall_cycles: got %0d want %0d", hs.stall_cycles, (1 << CW) - 1); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle(); hs.id_valid = 1; hs.id_reg_wr = 1; hs.id_long_lat = 1; hs.id_rd = 5'd4; tick();
    hs.id_rd = 5'd12; tick();
    idle(); #1;
    n_checks++; if (hs.sb_busy !== 1'b1) begin n_errors++; $display("FAIL reset_mid pre_busy: got %b want 1", hs.sb_busy); end
    rst = 1'b1; hs.br_taken = 1; hs.id_valid = 1; hs.id_reg_wr = 1; hs.id_long_lat = 1; hs.id_rd = 5'd5;
    tick();
    rst = 1'b0; idle(); #1;
    n_checks++; if (hs.sb_busy !== 1'b0) begin n_errors++; $display("FAIL reset_mid sb_busy: got %b want 0", hs.sb_busy); end
    n_checks++; if (hs.stall_cycles !== CW'(0)) begin n_errors++; $display("FAIL reset_mid stall_cycles: got %0d want 0", hs.stall_cycles); end
    n_checks++; if (hs.flush !== 1'b0) begin n_errors++; $display("FAIL reset_mid flush: got %b want 0", hs.flush); end
    hs.id_valid = 1; hs.id_rs1 = 5'd4; hs.id_rs1_used = 1; #1;
    n_checks++; if (hs.stall !== 1'b0) begin n_errors++; $display("FAIL reset_mid stall: got %b want 0", hs.stall); end
    n_checks++; if (hs.issue !== 1'b1) begin n_errors++; $display("FAIL reset_mid issue: got %b want 1", hs.issue); end
    tick();
  endtask

  initial begin
    test_reset();
    test_ex_fwd();
    test_load_use();
    test_scoreboard();
    test_x0();
    test_flush();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
